// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial add/subtract engine:
// FSM state encoding and the bit-counter width helper.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index bits 0..w-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder cell, time-shared by the serial engine.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract engine: one full_adder cell, one bit per
// clock LSB first, valid/ready request and result channels.
module serial_adder_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH:0]     res_shift_d;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Sum bit enters at the MSB; after WIDTH shifts the result is aligned.
  // Concatenate-and-slice keeps this legal for WIDTH=1.
  assign res_shift_d = {fa_s, res_q};

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge value of its neighbours (carry_q feeds ovf_q below).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          res_q   <= res_shift_d[WIDTH:1];
          carry_q <= fa_cout;
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB.
            cout_q  <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign res         = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model.
module tb_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sv;
  logic        rr;
  logic        sub_r;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        sel1;

  logic       sr8, rv8, co8, ov8;
  logic [7:0] res8;
  logic       sr1, rv1, co1, ov1;
  logic [0:0] res1;

  logic [31:0] obs_res;
  logic        obs_valid, obs_ready, obs_cout, obs_ovf;

  int tests_run;
  int tests_failed;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (sv & ~sel1),
    .start_ready (sr8),
    .op_a        (a32[7:0]),
    .op_b        (b32[7:0]),
    .sub         (sub_r),
    .res_valid   (rv8),
    .res_ready   (rr),
    .res         (res8),
    .cout        (co8),
    .ovf         (ov8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (sv & sel1),
    .start_ready (sr1),
    .op_a        (a32[0:0]),
    .op_b        (b32[0:0]),
    .sub         (sub_r),
    .res_valid   (rv1),
    .res_ready   (rr),
    .res         (res1),
    .cout        (co1),
    .ovf         (ov1)
  );

  always_comb begin
    obs_res   = sel1 ? 32'(res1) : 32'(res8);
    obs_valid = sel1 ? rv1 : rv8;
    obs_ready = sel1 ? sr1 : sr8;
    obs_cout  = sel1 ? co1 : co8;
    obs_ovf   = sel1 ? ov1 : ov8;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular and signed-integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] r,
                                output logic c, output logic o);
    longint m, ua, ub, sa, sb, v;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    if (s) begin
      v = ua - ub;
      c = (ua >= ub);
    end else begin
      v = ua + ub;
      c = (v >= m);
    end
    r  = 32'(v & (m - 1));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    v  = s ? sa - sb : sa + sb;
    o  = (v < -(m / 2)) || (v >= m / 2);
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    a32   = a;
    b32   = b;
    sub_r = s;
    sv    = 1'b1;
    n = 0;
    while (!obs_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic wait_valid(input int w);
    int lat;
    lat = 0;
    while (!obs_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(w));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [31:0] er;
    logic        ec, eo;
    int          w;
    w = sel1 ? 1 : 8;
    model(w, a, b, s, er, ec, eo);
    rr = (hold == 0);
    issue(a, b, s);
    wait_valid(w);
    for (int i = 0; i < hold; i++) begin
      check("hold_res", obs_res, er);
      check("hold_valid", 32'(obs_valid), 32'd1);
      check("hold_ready", 32'(obs_ready), 32'd0);
      @(negedge clk);
    end
    check("res", obs_res, er);
    check("cout", 32'(obs_cout), 32'(ec));
    check("ovf", 32'(obs_ovf), 32'(eo));
    check("valid", 32'(obs_valid), 32'd1);
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    check("valid_drop", 32'(obs_valid), 32'd0);
    check("ready_back", 32'(obs_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    logic        rs;
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    sv    = 1'b0;
    rr    = 1'b0;
    sub_r = 1'b0;
    a32   = '0;
    b32   = '0;
    sel1  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(obs_ready), 32'd1);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_res", obs_res, 32'd0);
    check("rst_cout", 32'(obs_cout), 32'd0);
    check("rst_ovf", 32'(obs_ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 arithmetic cases.
    run_op(32'h35, 32'h4A, 1'b0, 0);
    run_op(32'h7F, 32'h01, 1'b0, 0);
    run_op(32'hFF, 32'h01, 1'b0, 0);
    run_op(32'h10, 32'h20, 1'b1, 0);
    run_op(32'h80, 32'h01, 1'b1, 0);

    // Backpressure with an ignored start_valid pulse during DONE.
    rr = 1'b0;
    issue(32'h35, 32'h4A, 1'b0);
    wait_valid(8);
    for (int i = 0; i < 5; i++) begin
      check("bp_res", obs_res, 32'h7F);
      check("bp_valid", 32'(obs_valid), 32'd1);
      check("bp_ready", 32'(obs_ready), 32'd0);
      if (i == 2) begin
        a32 = 32'h11;
        b32 = 32'h22;
        sv  = 1'b1;
      end else begin
        sv = 1'b0;
      end
      @(negedge clk);
    end
    check("bp_res_end", obs_res, 32'h7F);
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    check("bp_idle_valid", 32'(obs_valid), 32'd0);
    check("bp_idle_ready", 32'(obs_ready), 32'd1);
    @(negedge clk);
    check("bp_no_accept", 32'(obs_ready), 32'd1);

    // Reset in the middle of RUN.
    issue(32'hAA, 32'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_ready", 32'(obs_ready), 32'd1);
    check("mrst_valid", 32'(obs_valid), 32'd0);
    check("mrst_res", obs_res, 32'd0);
    check("mrst_cout", 32'(obs_cout), 32'd0);
    run_op(32'h01, 32'h01, 1'b0, 0);

    // Random operations at both widths.
    for (int pass = 0; pass < 2; pass++) begin
      sel1 = (pass == 1);
      mask = sel1 ? 32'h1 : 32'hFF;
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom & mask;
        rb = $urandom & mask;
        rs = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(ra, rb, rs, int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
